// File: rtl/mic_adc_reader.sv
// Serial 10-bit microphone ADC reader: runs CS/SCLK framing and presents each conversion with a strobe.
// Optional build macro MIC_AVG_EN replaces the raw output with a 4-sample running average.
module mic_adc_reader #(
  parameter int CLK_DIV       = 12,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic       clk_48,
  input  logic       rst,
  input  logic       adc_dout,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic [9:0] mic_sample,
  output logic       sample_valid,
  output logic       busy
);

  localparam int PW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int HW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PERIOD_MAX = PW'(SAMPLE_PERIOD - 1);
  localparam logic [HW-1:0] HALF_MAX   = HW'(CLK_DIV - 1);
  localparam logic [9:0]    MID_SCALE  = 10'h200;
  localparam logic [4:0]    LAST_TOG   = 5'd26;
  localparam logic [4:0]    FIRST_DATA = 5'd6;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [PW-1:0] period_cnt;
  logic [HW-1:0] half_cnt;
  logic [4:0]    tog_cnt;
  logic [9:0]    shreg;
  logic          din_s1;
  logic          din_s2;
  logic          frame_end;

  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      din_s1 <= 1'b0;
      din_s2 <= 1'b0;
    end else begin
      din_s1 <= adc_dout;
      din_s2 <= din_s1;
    end
  end

  // Free-running; a frame is requested whenever it reads 0.
  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (period_cnt == PERIOD_MAX) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PW'(1);
    end
  end

  assign frame_end = (state == SHIFT) && (tog_cnt == LAST_TOG);

  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
      busy     <= 1'b0;
      half_cnt <= '0;
      tog_cnt  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (period_cnt == '0) begin
            state    <= SHIFT;
            adc_cs_n <= 1'b0;
            busy     <= 1'b1;
            half_cnt <= '0;
            tog_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (tog_cnt == LAST_TOG) begin
            state    <= DONE;
            adc_cs_n <= 1'b1;
            busy     <= 1'b0;
          end else if (half_cnt == HALF_MAX) begin
            half_cnt <= '0;
            adc_sclk <= ~adc_sclk;
            tog_cnt  <= tog_cnt + 5'd1;
            // Rising edges 1..3 carry sample/null bits; data starts at edge 4.
            if (!adc_sclk && (tog_cnt >= FIRST_DATA)) begin
              shreg <= {shreg[8:0], din_s2};
            end
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MIC_AVG_EN
  logic [9:0]  hist [4];
  logic        avg_pend;
  logic [11:0] avg_sum;

  always_comb begin
    avg_sum = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]} + {2'b00, hist[3]};
  end

  // History is pushed on the DONE edge; the averaged result appears one cycle later.
  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hist[i] <= MID_SCALE;
      end
      avg_pend     <= 1'b0;
      sample_valid <= 1'b0;
      mic_sample   <= MID_SCALE;
    end else begin
      avg_pend     <= frame_end;
      sample_valid <= avg_pend;
      if (frame_end) begin
        hist[0] <= shreg;
        hist[1] <= hist[0];
        hist[2] <= hist[1];
        hist[3] <= hist[2];
      end
      if (avg_pend) begin
        mic_sample <= avg_sum[11:2];
      end
    end
  end
`else
  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      sample_valid <= 1'b0;
      mic_sample   <= MID_SCALE;
    end else begin
      sample_valid <= frame_end;
      if (frame_end) begin
        mic_sample <= shreg;
      end
    end
  end
`endif

endmodule
